// File: rtl/lcd_nibble_tx.sv
// Physical-layer transmitter for a 4-bit HD44780-style LCD port: setup, enable pulse, hold, then execution delay.
// Optional sticky overrun flag and clear command are enabled by defining LCD_NIBBLE_TX_OVERRUN_EN.
module lcd_nibble_tx #(
   parameter int T_AS    = 2,
   parameter int T_EH    = 12,
   parameter int T_H     = 2,
   parameter int DELAY_W = 21
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               sendCommand,
   input  logic [4:0]         command,
   input  logic [DELAY_W-1:0] commandDelay,
   output logic [4:0]         LCD_D,
   output logic               LCD_E,
   output logic               commandDone,
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
   output logic               overrun,
`endif
   output logic               busy
);

   localparam int CNT_MAX = (T_AS > T_EH) ? ((T_AS > T_H) ? T_AS : T_H)
                                          : ((T_EH > T_H) ? T_EH : T_H);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]   AS_LOAD = CNT_W'(T_AS - 1);
   localparam logic [CNT_W-1:0]   EH_LOAD = CNT_W'(T_EH - 1);
   localparam logic [CNT_W-1:0]   H_LOAD  = CNT_W'(T_H - 1);
   localparam logic [CNT_W-1:0]   CNT_ZERO = '0;
   localparam logic [DELAY_W-1:0] DCNT_ONE = DELAY_W'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      E_HIGH = 3'd2,
      HOLD   = 3'd3,
      WAIT   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DELAY_W-1:0] dcnt_q, dcnt_d;
   logic [4:0]         lcd_d_q, lcd_d_d;
   logic               lcd_e_q, lcd_e_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
   logic               ovr_q, ovr_d;
   logic               clr_cmd;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dcnt_d  = dcnt_q;
      lcd_d_d = lcd_d_q;
      lcd_e_d = lcd_e_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
      ovr_d   = ovr_q;
      clr_cmd = (command == 5'b11111) && (commandDelay == '0);
      if (sendCommand && busy_q) begin
         ovr_d = 1'b1;
      end
`endif
      case (state_q)
         IDLE: begin
            if (sendCommand) begin
               busy_d = 1'b1;
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
               if (clr_cmd) begin
                  // Clear command skips the panel entirely; WAIT with dcnt 0 finishes next edge.
                  ovr_d   = 1'b0;
                  dcnt_d  = '0;
                  state_d = WAIT;
               end else begin
                  lcd_d_d = command;
                  dcnt_d  = commandDelay;
                  cnt_d   = AS_LOAD;
                  state_d = SETUP;
               end
`else
               lcd_d_d = command;
               dcnt_d  = commandDelay;
               cnt_d   = AS_LOAD;
               state_d = SETUP;
`endif
            end
         end
         SETUP: begin
            if (cnt_q == CNT_ZERO) begin
               lcd_e_d = 1'b1;
               cnt_d   = EH_LOAD;
               state_d = E_HIGH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         E_HIGH: begin
            if (cnt_q == CNT_ZERO) begin
               lcd_e_d = 1'b0;
               cnt_d   = H_LOAD;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            // dcnt already carries the delay captured at accept.
            if (cnt_q == CNT_ZERO) begin
               state_d = WAIT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WAIT: begin
            if (dcnt_q <= DCNT_ONE) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               dcnt_d  = '0;
               state_d = IDLE;
            end else begin
               dcnt_d = dcnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            lcd_e_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dcnt_q  <= '0;
         lcd_d_q <= '0;
         lcd_e_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
         ovr_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dcnt_q  <= dcnt_d;
         lcd_d_q <= lcd_d_d;
         lcd_e_q <= lcd_e_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
         ovr_q   <= ovr_d;
`endif
      end
   end

   assign LCD_D       = lcd_d_q;
   assign LCD_E       = lcd_e_q;
   assign commandDone = done_q;
   assign busy        = busy_q;
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
   assign overrun     = ovr_q;
`endif

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Testbench for lcd_nibble_tx: directed and random commands checked every cycle against a
// timeline model (accept edge plus fixed offsets); covers overrun when LCD_NIBBLE_TX_OVERRUN_EN is defined.
module tb_lcd_nibble_tx;

   localparam int T_AS = 2;
   localparam int T_EH = 12;
   localparam int T_H  = 2;
   localparam int DW   = 21;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          sendCommand = 1'b0;
   logic [4:0]    command = '0;
   logic [DW-1:0] commandDelay = '0;
   logic [4:0]    LCD_D;
   logic          LCD_E;
   logic          commandDone;
   logic          busy;
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
   logic          overrun;
`endif

   lcd_nibble_tx #(.T_AS(T_AS), .T_EH(T_EH), .T_H(T_H), .DELAY_W(DW)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .sendCommand(sendCommand),
      .command(command),
      .commandDelay(commandDelay),
      .LCD_D(LCD_D),
      .LCD_E(LCD_E),
      .commandDone(commandDone),
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
      .overrun(overrun),
`endif
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;

   // Timeline model: one active transfer described by its accept edge and total length.
   int         edge_n   = 0;
   bit         has_acc  = 1'b0;
   int         acc_edge = 0;
   int         acc_len  = 0;
   bit         acc_clr  = 1'b0;
   logic [4:0] exp_d    = '0;
   bit         exp_ovr  = 1'b0;

   function automatic bit model_busy();
      return has_acc && ((edge_n - acc_edge) < acc_len);
   endfunction

   function automatic bit model_done();
      return has_acc && ((edge_n - acc_edge) == acc_len);
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total_cnt++;
      assert (got === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_n);
      end
   endtask

   task automatic check_outputs();
      int k;
      bit e_exp;
      k = edge_n - acc_edge;
      e_exp = has_acc && !acc_clr && (k >= T_AS) && (k < T_AS + T_EH);
      check("LCD_D", 32'(LCD_D), 32'(exp_d));
      check("LCD_E", 32'(LCD_E), 32'(e_exp));
      check("commandDone", 32'(commandDone), 32'(model_done()));
      check("busy", 32'(busy), 32'(model_busy()));
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
      check("overrun", 32'(overrun), 32'(exp_ovr));
`endif
   endtask

   task automatic step();
      bit busy_before;
      bit clr;
      @(posedge CLK);
      busy_before = model_busy();
      edge_n++;
      if (!RST_N) begin
         has_acc = 1'b0;
         exp_d   = '0;
         exp_ovr = 1'b0;
      end else begin
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
         if (sendCommand && busy_before) exp_ovr = 1'b1;
`endif
         if (sendCommand && !busy_before) begin
            clr = 1'b0;
`ifdef LCD_NIBBLE_TX_OVERRUN_EN
            clr = (command == 5'b11111) && (commandDelay == '0);
`endif
            has_acc  = 1'b1;
            acc_edge = edge_n;
            acc_clr  = clr;
            if (clr) begin
               acc_len = 1;
               exp_ovr = 1'b0;
            end else begin
               acc_len = T_AS + T_EH + T_H + ((commandDelay == '0) ? 1 : int'(commandDelay));
               exp_d   = command;
            end
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   // One-cycle request, then scramble inputs to show they are only sampled at accept.
   task automatic send(logic [4:0] c, int d);
      command      = c;
      commandDelay = DW'(d);
      sendCommand  = 1'b1;
      step();
      sendCommand  = 1'b0;
      command      = 5'($urandom);
      commandDelay = DW'($urandom_range(0, 30));
   endtask

   initial begin
      RST_N = 1'b0;
      run(2);
      RST_N = 1'b1;
      run(2);

      // Nominal transfer: done expected 26 edges after accept.
      send(5'b00011, 10);
      run(30);

      // Delay 0 and 1 both finish 17 edges after accept.
      send(5'b10100, 0);
      run(20);
      send(5'b10100, 1);
      run(20);

      // Re-request during an active transfer is dropped.
      send(5'b01001, 6);
      run(4);
      command     = 5'b01111;
      sendCommand = 1'b1;
      step();
      sendCommand = 1'b0;
      run(25);

      // Request in the cycle commandDone is high is accepted.
      send(5'b00101, 3);
      for (int i = 0; i < 60 && !model_done(); i++) step();
      send(5'b00110, 4);
      run(25);

      // Asynchronous reset during E_HIGH.
      send(5'b11010, 8);
      run(5);
      RST_N = 1'b0;
      #1;
      check("async_LCD_E", 32'(LCD_E), 32'(0));
      check("async_LCD_D", 32'(LCD_D), 32'(0));
      check("async_busy", 32'(busy), 32'(0));
      run(2);
      RST_N = 1'b1;
      run(3);
      send(5'b01100, 5);
      run(30);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         sendCommand  = ($urandom_range(0, 3) == 0);
         command      = 5'($urandom);
         commandDelay = DW'($urandom_range(0, 12));
         step();
      end
      sendCommand = 1'b0;
      run(40);

`ifdef LCD_NIBBLE_TX_OVERRUN_EN
      send(5'b00001, 5);
      run(3);
      command     = 5'b00010;
      sendCommand = 1'b1;
      step();
      sendCommand = 1'b0;
      run(30);
      send(5'b11111, 0);
      run(5);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/lcd_nibble_tx.md
Name: lcd_nibble_tx

Overview:
- Physical-layer stage for the 4-bit HD44780-style LCD port.
- Consumes one 5-bit command ({RS, D[3:0]}) plus a post-command delay from the LCD sequencer: init-and-text controller upstream, `sendCommand`/`commandDone` handshake.
- Drives LCD_D and LCD_E with the required address-setup, enable-pulse and hold timing.
- Then waits out the command execution delay and pulses `commandDone`.

Parameters:
- T_AS, 2, address/RS setup cycles from LCD_D change to LCD_E rise (≥40 ns at 50 MHz); must be ≥1.
- T_EH, 12, LCD_E high-pulse width in cycles (≥230 ns at 50 MHz); must be ≥1.
- T_H, 2, cycles LCD_D is held stable after LCD_E fall before the delay phase starts; must be ≥1.
- DELAY_W, 21, width of `commandDelay` and of the delay counter.

Ports:
- CLK  input  1  system clock, 50 MHz.
- RST_N  input  1  asynchronous active-low reset.
- sendCommand  input  1  one-cycle request; sampled only in IDLE.
- command  input  5  bit4 = RS, bits3:0 = data nibble.
- commandDelay  input  DELAY_W  post-enable wait in CLK cycles; 0 is treated as 1.
- LCD_D  output  5  registered {RS, nibble} to the panel.
- LCD_E  output  1  registered enable strobe.
- commandDone  output  1  one-cycle pulse when the command and its delay have completed.
- busy  output  1  high from the accept edge until the edge that raises `commandDone`.

Behaviour:
- Reset (RST_N low, asynchronous):
  - LCD_D = 0, LCD_E = 0, commandDone = 0, busy = 0.
  - State = IDLE; all counters = 0.
  - Reset mid-transfer drops LCD_E immediately. No `commandDone` is produced for the aborted command.
- States: IDLE → SETUP → E_HIGH → HOLD → WAIT → IDLE.
- Accept edge (IDLE, sendCommand = 1):
  - LCD_D <= command; latch commandDelay; busy <= 1.
  - Enter SETUP with cnt = T_AS-1.
- SETUP:
  - If cnt == 0: LCD_E <= 1, enter E_HIGH with cnt = T_EH-1.
  - Else cnt--.
- E_HIGH:
  - If cnt == 0: LCD_E <= 0, enter HOLD with cnt = T_H-1.
  - Else cnt--.
- HOLD:
  - If cnt == 0: enter WAIT with dcnt = latched delay.
  - Else cnt--.
- WAIT:
  - If dcnt ≤ 1: commandDone <= 1, busy <= 0, enter IDLE.
  - Else dcnt--.
- commandDone is high for exactly one cycle, then self-clears.
- Timing relative to the accept edge (edge 0):
  - LCD_E rises at edge T_AS.
  - LCD_E falls at edge T_AS+T_EH.
  - commandDone rises at edge T_AS+T_EH+T_H+max(D,1).
- LCD_D is held after completion until the next accept. LCD_D never changes while LCD_E is high or during HOLD.
- The `command` and `commandDelay` inputs are sampled only at the accept edge. Later input changes have no effect on the transfer in progress.
- sendCommand while busy is ignored: not queued, no state change.
- sendCommand asserted in the cycle where commandDone is high is accepted, because state is already IDLE. Back-to-back throughput is one command per T_AS+T_EH+T_H+max(D,1)+1 cycles.
- Counter widths:
  - cnt is sized for the largest of T_AS, T_EH, T_H.
  - dcnt is DELAY_W bits, with no wrap: the maximum delay is 2^DELAY_W-1 cycles.

Optional Feature:
- Macro: LCD_NIBBLE_TX_OVERRUN_EN.
- When defined:
  - Adds output `overrun` (1 bit, reset 0).
  - `overrun` is set sticky when sendCommand = 1 while busy = 1.
  - It is cleared only by reset or by an accepted command with command = 5'b11111 and commandDelay = 0.
  - In that clearing case the command is consumed without driving LCD_D or LCD_E, and commandDone pulses one cycle after accept.
- When not defined:
  - No `overrun` port.
  - Requests while busy are silently dropped.
  - 5'b11111 is transferred like any other command.

Test Plan:
- Reset, then sendCommand with command = 5'b00011, commandDelay = 10 (accept edge 0) → LCD_D = 5'b00011 from edge 0; LCD_E high edges 2–13; commandDone single pulse at edge 26; busy low at edge 26.
- commandDelay = 0 vs 1, with command = 5'b10100 → commandDone at edge 17 in both cases; LCD_D = 5'b10100 held afterwards.
- sendCommand re-pulsed at edge 5 with command = 5'b01111 during an active transfer → ignored; LCD_D stays at the first command; exactly one commandDone.
- sendCommand asserted in the same cycle commandDone is high, with a new command 5'b00110 → accepted; LCD_D updates at that edge; LCD_E rises T_AS = 2 cycles later.
- RST_N pulsed low during E_HIGH → LCD_E = 0 and LCD_D = 0 asynchronously; no commandDone; a following command executes with nominal timing.
- With LCD_NIBBLE_TX_OVERRUN_EN: request while busy → overrun = 1 and stays 1. Then command 5'b11111 with delay 0 → overrun = 0, no LCD_E pulse, commandDone one cycle after accept.
